// File: rtl/heq_pkg.sv
// Shared definitions for the histogram-equalization sequencer: state codes,
// scratchpad port widths and the scratchpad request bundle.
package heq_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;

  // Encodings are visible on the phase output, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_CDF   = 3'd3,
    ST_MAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] wval;
  } m2_req_t;

  function automatic logic is_stage(input state_t s);
    return s inside {ST_COUNT, ST_CDF, ST_MAP};
  endfunction

endpackage

// File: rtl/heq_m2_arbiter.sv
// Scratchpad port multiplexer: hands the m2 port to whichever block owns the
// current phase; purely combinational so a grant reaches the port in 0 cycles.
module heq_m2_arbiter
  import heq_pkg::*;
(
  input  state_t            state,
  input  logic [ADDR_W-1:0] clr_addr,
  input  m2_req_t           cnt_req,
  input  m2_req_t           cdf_req,
  input  m2_req_t           map_req,
  output m2_req_t           grant
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch can be inferred for states without an arm.
    grant = '0;
    case (state)
      ST_CLEAR: begin
        grant.we    = 1'b1;
        grant.waddr = clr_addr;
      end
      ST_COUNT: grant = cnt_req;
      ST_CDF:   grant = cdf_req;
      ST_MAP:   grant = map_req;
      default:  ;
    endcase
  end

endmodule

// File: rtl/heq_sequencer.sv
// Run controller for histogram equalization: optional scratch clear, then
// COUNT/CDF/MAP stages with a per-phase watchdog. Clear is built only when
// HEQ_SCRATCH_CLEAR_EN is defined.
module heq_sequencer
  import heq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned NUM_BINS       = 256
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cnt_done,
  input  logic              cdf_done,
  input  logic              map_done,
  output logic              cnt_start,
  output logic              cdf_start,
  output logic              map_start,
  input  logic              cnt_m2WE,
  input  logic              cdf_m2WE,
  input  logic              map_m2WE,
  input  logic [ADDR_W-1:0] cnt_m2WriteAddr,
  input  logic [ADDR_W-1:0] cdf_m2WriteAddr,
  input  logic [ADDR_W-1:0] map_m2WriteAddr,
  input  logic [ADDR_W-1:0] cnt_m2ReadAddr,
  input  logic [ADDR_W-1:0] cdf_m2ReadAddr,
  input  logic [ADDR_W-1:0] map_m2ReadAddr,
  input  logic [DATA_W-1:0] cnt_m2WriteVal,
  input  logic [DATA_W-1:0] cdf_m2WriteVal,
  input  logic [DATA_W-1:0] map_m2WriteVal,
  output logic              m2WE,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [ADDR_W-1:0] m2ReadAddr,
  output logic [DATA_W-1:0] m2WriteVal,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        phase
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef HEQ_SCRATCH_CLEAR_EN
  localparam state_t RUN_ENTRY = ST_CLEAR;
`else
  localparam state_t RUN_ENTRY = ST_COUNT;
`endif

  state_t            state, state_nxt;
  logic [WD_W-1:0]   wd, wd_nxt;
  logic              timeout;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr;

  // ---------------------------------------------------------------------------
  // Scratch clear index
  // ---------------------------------------------------------------------------
`ifdef HEQ_SCRATCH_CLEAR_EN
  localparam int CLR_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_BINS - 1);

  logic [CLR_W-1:0] clr_idx;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
    end else begin
      clr_idx <= '0;
    end
  end

  assign clr_last = (clr_idx == CLR_LAST);
  assign clr_addr = ADDR_W'(clr_idx);
`else
  // Bin count only matters when the scratchpad is cleared in hardware.
  logic unused_num_bins;
  assign unused_num_bins = ^ADDR_W'(NUM_BINS);
  assign clr_last        = 1'b0;
  assign clr_addr        = '0;
`endif

  // ---------------------------------------------------------------------------
  // State and watchdog
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wd    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state <= state_nxt;
      wd    <= wd_nxt;
    end
  end

  assign timeout = (wd == WD_LAST);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: if (start) state_nxt = RUN_ENTRY;
`ifdef HEQ_SCRATCH_CLEAR_EN
        ST_CLEAR:          if (clr_last) state_nxt = ST_COUNT;
`endif
        ST_COUNT: begin
          if (cnt_done)     state_nxt = ST_CDF;
          else if (timeout) state_nxt = ST_ERROR;
        end
        ST_CDF: begin
          if (cdf_done)     state_nxt = ST_MAP;
          else if (timeout) state_nxt = ST_ERROR;
        end
        ST_MAP: begin
          if (map_done)     state_nxt = ST_DONE;
          else if (timeout) state_nxt = ST_ERROR;
        end
        ST_DONE:            state_nxt = ST_IDLE;
        default:            state_nxt = ST_IDLE;
      endcase
    end
  end

  // The watchdog only runs while a stage keeps the phase; any phase change
  // (including entry to the next stage) reloads it to zero.
  always_comb begin
    wd_nxt = '0;
    if (is_stage(state) && (state_nxt == state)) begin
      wd_nxt = wd + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status and launch pulses
  // ---------------------------------------------------------------------------
  assign cnt_start = (state == ST_COUNT) && (wd == '0);
  assign cdf_start = (state == ST_CDF)   && (wd == '0);
  assign map_start = (state == ST_MAP)   && (wd == '0);

  assign busy  = is_stage(state) || (state == ST_CLEAR);
  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERROR);
  assign phase = state;

  // ---------------------------------------------------------------------------
  // Scratchpad port
  // ---------------------------------------------------------------------------
  m2_req_t cnt_req, cdf_req, map_req, grant;

  assign cnt_req = '{we: cnt_m2WE, waddr: cnt_m2WriteAddr, raddr: cnt_m2ReadAddr, wval: cnt_m2WriteVal};
  assign cdf_req = '{we: cdf_m2WE, waddr: cdf_m2WriteAddr, raddr: cdf_m2ReadAddr, wval: cdf_m2WriteVal};
  assign map_req = '{we: map_m2WE, waddr: map_m2WriteAddr, raddr: map_m2ReadAddr, wval: map_m2WriteVal};

  heq_m2_arbiter u_arbiter (
    .state    (state),
    .clr_addr (clr_addr),
    .cnt_req  (cnt_req),
    .cdf_req  (cdf_req),
    .map_req  (map_req),
    .grant    (grant)
  );

  assign m2WE        = grant.we;
  assign m2WriteAddr = grant.waddr;
  assign m2ReadAddr  = grant.raddr;
  assign m2WriteVal  = grant.wval;

endmodule

// File: tb/tb_heq_sequencer.sv
// Directed bench for heq_sequencer (TIMEOUT_CYCLES=16, NUM_BINS=256); follows
// HEQ_SCRATCH_CLEAR_EN so the same bench covers both builds.
module tb_heq_sequencer;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         cnt_done = 1'b0, cdf_done = 1'b0, map_done = 1'b0;
  logic         cnt_start, cdf_start, map_start;
  logic         cnt_m2WE = 1'b1, cdf_m2WE = 1'b1, map_m2WE = 1'b0;
  logic [15:0]  cnt_m2WriteAddr = 16'h1111, cdf_m2WriteAddr = 16'h2222, map_m2WriteAddr = 16'h3333;
  logic [15:0]  cnt_m2ReadAddr  = 16'h1A1A, cdf_m2ReadAddr  = 16'h2B2B, map_m2ReadAddr  = 16'h3C3C;
  logic [127:0] cnt_m2WriteVal  = {8{16'hC0C0}};
  logic [127:0] cdf_m2WriteVal  = {8{16'hD1D1}};
  logic [127:0] map_m2WriteVal  = {8{16'hE2E2}};
  logic         m2WE;
  logic [15:0]  m2WriteAddr, m2ReadAddr;
  logic [127:0] m2WriteVal;
  logic         busy, done, error;
  logic [2:0]   phase;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [159:0] CNT_BUS  = {16'h1111, 16'h1A1A, {8{16'hC0C0}}};
  localparam logic [159:0] CDF_BUS  = {16'h2222, 16'h2B2B, {8{16'hD1D1}}};
  localparam logic [159:0] MAP_BUS  = {16'h3333, 16'h3C3C, {8{16'hE2E2}}};
  localparam logic [159:0] ZERO_BUS = '0;

  always #5 clock = ~clock;

  heq_sequencer #(.TIMEOUT_CYCLES(16), .NUM_BINS(256)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .cnt_done(cnt_done), .cdf_done(cdf_done), .map_done(map_done),
    .cnt_start(cnt_start), .cdf_start(cdf_start), .map_start(map_start),
    .cnt_m2WE(cnt_m2WE), .cdf_m2WE(cdf_m2WE), .map_m2WE(map_m2WE),
    .cnt_m2WriteAddr(cnt_m2WriteAddr), .cdf_m2WriteAddr(cdf_m2WriteAddr), .map_m2WriteAddr(map_m2WriteAddr),
    .cnt_m2ReadAddr(cnt_m2ReadAddr), .cdf_m2ReadAddr(cdf_m2ReadAddr), .map_m2ReadAddr(map_m2ReadAddr),
    .cnt_m2WriteVal(cnt_m2WriteVal), .cdf_m2WriteVal(cdf_m2WriteVal), .map_m2WriteVal(map_m2WriteVal),
    .m2WE(m2WE), .m2WriteAddr(m2WriteAddr), .m2ReadAddr(m2ReadAddr), .m2WriteVal(m2WriteVal),
    .busy(busy), .done(done), .error(error), .phase(phase)
  );

  // Status word: {busy, done, error, phase, cnt_start, cdf_start, map_start, m2WE}
  wire [9:0]   st  = {busy, done, error, phase, cnt_start, cdf_start, map_start, m2WE};
  wire [159:0] bus = {m2WriteAddr, m2ReadAddr, m2WriteVal};

  function automatic logic [9:0] es(input logic b, input logic d, input logic e, input logic [2:0] ph,
                                    input logic cs, input logic ds, input logic ms, input logic we);
    return {b, d, e, ph, cs, ds, ms, we};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Launch a run and stop on the first COUNT cycle.
  task automatic go_count();
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef HEQ_SCRATCH_CLEAR_EN
    repeat (256) step();
`endif
  endtask

  // Launch a run and stop on the first MAP cycle.
  task automatic go_map();
    go_count();
    cnt_done = 1'b1; step(); cnt_done = 1'b0;
    cdf_done = 1'b1; step(); cdf_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    #12;
    e = es(0, 0, 0, 3'd0, 0, 0, 0, 0);
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL reset_state: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
    #1 rst_n = 1'b1;
    step();
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL idle_after_reset: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
  endtask

  task automatic test_nominal();
    logic [9:0]   e;
    logic [159:0] eb;
`ifndef HEQ_SCRATCH_CLEAR_EN
    e = es(0, 0, 0, 3'd0, 0, 0, 0, 0);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef HEQ_SCRATCH_CLEAR_EN
    e = es(1, 0, 0, 3'd1, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      eb = {i[15:0], 16'h0000, 128'h0};
      vectors++;
      if (st !== e || bus !== eb) begin
        miscompares++;
        $display("FAIL clear_write[%0d]: status %b bus %h, expected status %b bus %h", i, st, bus, e, eb);
      end
      step();
    end
`endif
    e = es(1, 0, 0, 3'd2, 1, 0, 0, 1);
    vectors++;
    if (st !== e || bus !== CNT_BUS) begin
      miscompares++;
      $display("FAIL count_entry: status %b bus %h, expected status %b bus %h", st, bus, e, CNT_BUS);
    end
    step();
    e = es(1, 0, 0, 3'd2, 0, 0, 0, 1);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL count_start_one_cycle: status %b, expected %b", st, e);
    end
    cnt_done = 1'b1; step(); cnt_done = 1'b0;
    e = es(1, 0, 0, 3'd3, 0, 1, 0, 1);
    vectors++;
    if (st !== e || bus !== CDF_BUS) begin
      miscompares++;
      $display("FAIL cdf_entry: status %b bus %h, expected status %b bus %h", st, bus, e, CDF_BUS);
    end
    cdf_done = 1'b1; step(); cdf_done = 1'b0;
    e = es(1, 0, 0, 3'd4, 0, 0, 1, 0);
    vectors++;
    if (st !== e || bus !== MAP_BUS) begin
      miscompares++;
      $display("FAIL map_entry: status %b bus %h, expected status %b bus %h", st, bus, e, MAP_BUS);
    end
    map_done = 1'b1; step(); map_done = 1'b0;
    e = es(0, 1, 0, 3'd5, 0, 0, 0, 0);
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL done_pulse: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
    step();
    e = es(0, 0, 0, 3'd0, 0, 0, 0, 0);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL idle_after_done: status %b, expected %b", st, e);
    end
  endtask

  task automatic test_stray();
    logic [9:0] e;
    go_count();
    map_done = 1'b1; cdf_done = 1'b1;
    step();
    map_done = 1'b0; cdf_done = 1'b0;
    e = es(1, 0, 0, 3'd2, 0, 0, 0, 1);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL stray_done_in_count: status %b, expected %b", st, e);
    end
    cnt_m2WE = 1'b0;
    #1;
    e = es(1, 0, 0, 3'd2, 0, 0, 0, 0);
    vectors++;
    if (st !== e || bus !== CNT_BUS) begin
      miscompares++;
      $display("FAIL owner_we_only: status %b bus %h, expected status %b bus %h", st, bus, e, CNT_BUS);
    end
    cnt_m2WE = 1'b1;
    cnt_done = 1'b1; step(); cnt_done = 1'b0;
    start = 1'b1; cnt_done = 1'b1;
    step();
    start = 1'b0; cnt_done = 1'b0;
    e = es(1, 0, 0, 3'd3, 0, 0, 0, 1);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL start_in_cdf_ignored: status %b, expected %b", st, e);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    logic [9:0] e;
    go_count();
    repeat (15) step();
    cnt_done = 1'b1; step(); cnt_done = 1'b0;
    e = es(1, 0, 0, 3'd3, 0, 1, 0, 1);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL done_beats_timeout: status %b, expected %b", st, e);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    go_count();
    cnt_done = 1'b1; step(); cnt_done = 1'b0;
    repeat (15) step();
    e = es(1, 0, 0, 3'd3, 0, 0, 0, 1);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL cdf_last_cycle: status %b, expected %b", st, e);
    end
    step();
    e = es(0, 0, 1, 3'd6, 0, 0, 0, 0);
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL timeout_error: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
    cdf_done = 1'b1; step(); cdf_done = 1'b0;
    repeat (2) step();
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL error_sticky: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
    start = 1'b1; step(); start = 1'b0;
`ifdef HEQ_SCRATCH_CLEAR_EN
    e = es(1, 0, 0, 3'd1, 0, 0, 0, 1);
`else
    e = es(1, 0, 0, 3'd2, 1, 0, 0, 1);
`endif
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL restart_from_error: status %b, expected %b", st, e);
    end
    abort = 1'b1; step(); abort = 1'b0;
    e = es(0, 0, 0, 3'd0, 0, 0, 0, 0);
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL abort_to_idle: status %b, expected %b", st, e);
    end
  endtask

  task automatic test_abort_collision();
    logic [9:0] e;
    go_map();
    abort = 1'b1; map_done = 1'b1;
    step();
    abort = 1'b0; map_done = 1'b0;
    e = es(0, 0, 0, 3'd0, 0, 0, 0, 0);
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL abort_vs_map_done: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
    step();
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL no_done_after_abort: status %b, expected %b", st, e);
    end
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL abort_vs_start: status %b, expected %b", st, e);
    end
  endtask

  task automatic test_reset_midrun();
    logic [9:0] e;
    go_map();
    rst_n = 1'b0;
    #1;
    e = es(0, 0, 0, 3'd0, 0, 0, 0, 0);
    vectors++;
    if (st !== e || bus !== ZERO_BUS) begin
      miscompares++;
      $display("FAIL reset_in_map: status %b bus %h, expected status %b bus 0", st, bus, e);
    end
    step();
    vectors++;
    if (st !== e) begin
      miscompares++;
      $display("FAIL no_done_during_reset: status %b, expected %b", st, e);
    end
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
`ifdef HEQ_SCRATCH_CLEAR_EN
    e = es(1, 0, 0, 3'd1, 0, 0, 0, 1);
`else
    e = es(1, 0, 0, 3'd2, 1, 0, 0, 1);
`endif
    vectors++;
    if (st !== e || (phase == 3'd1 && m2WriteAddr !== 16'h0000)) begin
      miscompares++;
      $display("FAIL fresh_run_after_reset: status %b addr %h, expected status %b addr 0", st, m2WriteAddr, e);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stray();
    test_timeout_boundary();
    test_timeout();
    test_abort_collision();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/heq_sequencer.md
HEQ_SEQUENCER -- requirements
Module: heq_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum cycles allowed per COUNT/CDF/MAP phase before error.
REQ-002 SHALL have parameter NUM_BINS, default 256, giving the scratchpad histogram bins cleared per run.
REQ-003 SHALL have port clock, input, 1 bit: the system clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin one equalization run.
REQ-006 SHALL have port abort, input, 1 bit: cancel the current run.
REQ-007 SHALL have ports cnt_done, cdf_done and map_done, input, 1 bit each: completion pulses from the stages.
REQ-008 SHALL have ports cnt_start, cdf_start and map_start, output, 1 bit each: one-cycle stage launch pulses.
REQ-009 SHALL have ports cnt_m2WE, cdf_m2WE and map_m2WE, input, 1 bit each: per-stage scratchpad write enables.
REQ-010 SHALL have ports cnt_m2WriteAddr, cdf_m2WriteAddr, map_m2WriteAddr, cnt_m2ReadAddr, cdf_m2ReadAddr and map_m2ReadAddr, input, 16 bits each: per-stage scratchpad addresses.
REQ-011 SHALL have ports cnt_m2WriteVal, cdf_m2WriteVal and map_m2WriteVal, input, 128 bits each: per-stage write data.
REQ-012 SHALL have ports m2WE (1 bit), m2WriteAddr (16 bits), m2ReadAddr (16 bits) and m2WriteVal (128 bits), output: the arbitrated scratchpad port.
REQ-013 SHALL have ports busy, done and error, output, 1 bit each, plus port phase, output, 3 bits: current state code.

Function
REQ-014 SHALL implement states IDLE, CLEAR, COUNT, CDF, MAP, DONE and ERROR.
REQ-015 SHALL move IDLE->CLEAR when start=1, or IDLE->COUNT when start=1 and clear is compiled out.
REQ-016 SHALL ignore start outside IDLE and ERROR.
REQ-017 SHALL write zero to m2WriteAddr 0..NUM_BINS-1 in CLEAR, one address per cycle with m2WE=1, then enter COUNT after exactly NUM_BINS cycles.
REQ-018 SHALL pulse the matching *_start output for exactly one cycle, on the first cycle of COUNT, CDF or MAP.
REQ-019 SHALL advance COUNT->CDF on cnt_done, CDF->MAP on cdf_done, and MAP->DONE on map_done, each taking effect the following cycle.
REQ-020 SHALL ignore any *_done pulse that does not match the current phase.
REQ-021 SHALL pass only the current phase owner's m2 signals (COUNT=cnt, CDF=cdf, MAP=map) to the m2 outputs, with m2WE=0 and addresses/data at 0 in IDLE, DONE and ERROR.
REQ-022 SHALL keep the m2 outputs purely combinational from state, so that grant-to-port latency is 0 cycles.
REQ-023 SHALL reload the watchdog counter to 0 on entry to COUNT, CDF and MAP, and increment it every cycle in those phases.
REQ-024 SHALL enter ERROR when the watchdog reaches TIMEOUT_CYCLES-1 without the matching done, with the done taking priority if it arrives in that same cycle.
REQ-025 SHALL hold error=1 (sticky) in ERROR until start or abort, where start clears error and begins a new run as from IDLE.
REQ-026 SHALL send every state to IDLE on the next cycle when abort=1, with abort taking priority over simultaneous done, start or timeout, and no done pulse issued.
REQ-027 SHALL make DONE last one cycle, with done=1 only in that cycle, then return to IDLE.
REQ-028 SHALL drive busy=1 in CLEAR, COUNT, CDF and MAP.

Reset
REQ-029 SHALL on rst_n=0 immediately force state IDLE, watchdog 0, clear index 0, all *_start 0, done 0, error 0, busy 0, m2WE 0, and all m2 addresses and data 0.
REQ-030 SHALL treat reset mid-run as a full abort, with no done pulse issued.

Configuration
REQ-031 SHALL compile the CLEAR state and clear counter in when macro HEQ_SCRATCH_CLEAR_EN is defined, and remove them with start going directly to COUNT when it is undefined.

Structure
REQ-032 SHALL take the state enumeration and phase codes (IDLE=0, CLEAR=1, COUNT=2, CDF=3, MAP=4, DONE=5, ERROR=6) from shared package heq_pkg.
REQ-033 SHALL take the address/data width constants (16/128) from heq_pkg.
REQ-034 SHALL implement the m2 port multiplexer as sub-module heq_m2_arbiter.

Verification
REQ-035 SHALL verify a nominal run with the macro defined: start pulse -> 256 zero writes to addresses 0..255, cnt_start on cycle 257, then cnt/cdf/map done in turn -> done=1 for 1 cycle and phase=0 after.
REQ-036 SHALL verify a timeout: TIMEOUT_CYCLES=16 and no cdf_done -> ERROR 16 cycles after CDF entry, error=1 held, m2WE=0.
REQ-037 SHALL verify abort/done collision: abort and map_done in the same cycle -> IDLE, done stays 0.
REQ-038 SHALL verify stray signals: map_done during COUNT -> ignored; start during CDF -> ignored; cdf_m2WE=1 during COUNT -> m2WE follows cnt_m2WE only.
REQ-039 SHALL verify reset mid-run: rst_n low during MAP -> all outputs 0 immediately; next start -> a fresh run.
REQ-040 SHALL verify the macro-undefined build: start -> cnt_start on the next cycle, and no CLEAR writes.
